// File: rtl/ccr_pkg.sv
// Shared definitions for the condition-code register: branch type codes and flag bit positions.
package ccr_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_JZ   = 3'b001,
        BR_JN   = 3'b010,
        BR_JC   = 3'b011,
        BR_JV   = 3'b100,
        BR_LOOP = 3'b101,
        BR_JMP  = 3'b110,
        BR_RET  = 3'b111
    } br_type_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/ccr_shadow_stack.sv
// LIFO of 4-bit flag snapshots used to save and restore flags across nested interrupts.
module ccr_shadow_stack #(
    parameter int NEST_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [3:0] push_data,
    output logic [3:0] pop_data,
    output logic       pop_ok,
    output logic       empty,
    output logic       full,
    output logic       err
);

    localparam int PTR_W = $clog2(NEST_DEPTH + 1);

    logic [3:0]       mem_q [NEST_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] top_idx;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             push_ok;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        push_ok  = push & ~full_q;
        pop_ok   = pop & ~empty_q;
        err      = (push & full_q) | (pop & empty_q);
        top_idx  = ptr_q - PTR_W'(1);
        pop_data = '0;
        for (int i = 0; i < NEST_DEPTH; i++) begin
            if (top_idx == PTR_W'(i)) pop_data = mem_q[i];
        end
        ptr_d = ptr_q;
        if (pop_ok)       ptr_d = ptr_q - PTR_W'(1);
        else if (push_ok) ptr_d = ptr_q + PTR_W'(1);
        empty_d = (ptr_d == '0);
        full_d  = (ptr_d == PTR_W'(NEST_DEPTH));
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    // NOTE: storage is not reset; an empty pointer makes its contents unreachable.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            for (int i = 0; i < NEST_DEPTH; i++) begin
                if (ptr_q == PTR_W'(i)) mem_q[i] <= push_data;
            end
        end
    end

    assign empty = empty_q;
    assign full  = full_q;

endmodule

// File: rtl/ccr_flag_unit.sv
// Condition-code register with priority flag merge, interrupt shadow stack and sticky errors.
// Build option: define FLAG_FWD_EN to forward same-cycle ALU/SETC/CLRC/restore results to flag_mask.
module ccr_flag_unit
    import ccr_pkg::*;
#(
    parameter int NEST_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] alu_flags,
    input  logic [3:0] alu_flag_we,
    input  logic       setc,
    input  logic       clrc,
    input  logic       b_take,
    input  logic [2:0] btype,
    input  logic       int_save,
    input  logic       int_restore,
    output logic [3:0] flag_mask,
    output logic       shadow_empty,
    output logic       shadow_full,
    output logic       stk_err,
    output logic       proto_err
);

    logic [3:0] flags_q, flags_d;
    logic [3:0] wr_val, wr_mask, clr_mask;
    logic [3:0] pop_data;
    logic       pop_ok, stack_err, push_req;
    logic       stk_err_q, stk_err_d;
    logic       proto_err_q, proto_err_d;

    // Restore wins over save, so a simultaneous save never reaches the stack.
    assign push_req = int_save & ~int_restore;

    ccr_shadow_stack #(.NEST_DEPTH(NEST_DEPTH)) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .pop       (int_restore),
        .push_data (flags_q),
        .pop_data  (pop_data),
        .pop_ok    (pop_ok),
        .empty     (shadow_empty),
        .full      (shadow_full),
        .err       (stack_err)
    );

    always_comb begin
        clr_mask = '0;
        if (b_take) begin
            case (br_type_e'(btype))
                BR_JZ:   clr_mask[FLAG_Z] = 1'b1;
                BR_JN:   clr_mask[FLAG_N] = 1'b1;
                BR_JC:   clr_mask[FLAG_C] = 1'b1;
                BR_JV:   clr_mask[FLAG_V] = 1'b1;
                default: clr_mask = '0;
            endcase
        end

        // Written bits override consume-clear; applied lowest to highest priority.
        wr_mask = alu_flag_we;
        wr_val  = alu_flags;
        if (setc | clrc) begin
            wr_mask[FLAG_C] = 1'b1;
            wr_val[FLAG_C]  = (setc & clrc) ? flags_q[FLAG_C] : setc;
        end
        if (pop_ok) begin
            wr_mask = 4'hF;
            wr_val  = pop_data;
        end

        flags_d     = (wr_val & wr_mask) | (flags_q & ~clr_mask & ~wr_mask);
        stk_err_d   = stk_err_q | stack_err;
        proto_err_d = proto_err_q | (setc & clrc) | (int_save & int_restore);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q     <= '0;
            stk_err_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            flags_q     <= flags_d;
            stk_err_q   <= stk_err_d;
            proto_err_q <= proto_err_d;
        end
    end

`ifdef FLAG_FWD_EN
    // Consume-clear is left out so b_take has no combinational path back to flag_mask.
    assign flag_mask = (wr_val & wr_mask) | (flags_q & ~wr_mask);
`else
    assign flag_mask = flags_q;
`endif

    assign stk_err   = stk_err_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_ccr_flag_unit.sv
// Directed self-checking bench for ccr_flag_unit (default build, NEST_DEPTH=2).
module tb_ccr_flag_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] alu_flags, alu_flag_we;
    logic       setc, clrc, b_take;
    logic [2:0] btype;
    logic       int_save, int_restore;
    logic [3:0] flag_mask;
    logic       shadow_empty, shadow_full, stk_err, proto_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ccr_flag_unit #(.NEST_DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_flags    (alu_flags),
        .alu_flag_we  (alu_flag_we),
        .setc         (setc),
        .clrc         (clrc),
        .b_take       (b_take),
        .btype        (btype),
        .int_save     (int_save),
        .int_restore  (int_restore),
        .flag_mask    (flag_mask),
        .shadow_empty (shadow_empty),
        .shadow_full  (shadow_full),
        .stk_err      (stk_err),
        .proto_err    (proto_err)
    );

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; alu_flags = '0; alu_flag_we = '0; setc = 1'b0; clrc = 1'b0;
        b_take = 1'b0; btype = 3'b000; int_save = 1'b0; int_restore = 1'b0;
    endtask

    // One clock; outputs are sampled 1 time unit after the edge, then inputs return to idle.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic load_flags(input logic [3:0] v);
        alu_flag_we = 4'hF; alu_flags = v;
        step();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step();
        rst = 1'b1;
        step();
        check("rst_flags", flag_mask, 4'b0000);
        check("rst_empty", {3'b0, shadow_empty}, 4'd1);
        check("rst_full", {3'b0, shadow_full}, 4'd0);
        check("rst_stk_err", {3'b0, stk_err}, 4'd0);
        check("rst_proto_err", {3'b0, proto_err}, 4'd0);

        load_flags(4'b0101);
        check("alu_write", flag_mask, 4'b0101);

        load_flags(4'b0001);
        b_take = 1'b1; btype = 3'b001;
        step();
        check("consume_jz", flag_mask, 4'b0000);

        load_flags(4'b0001);
        b_take = 1'b1; btype = 3'b101;
        step();
        check("loop_no_clear", flag_mask, 4'b0001);

        b_take = 1'b1; btype = 3'b001; alu_flag_we = 4'b0001; alu_flags = 4'b0001;
        step();
        check("alu_beats_clear", flag_mask, 4'b0001);

        load_flags(4'b1111);
        b_take = 1'b1; btype = 3'b011;
        step();
        check("consume_jc", flag_mask, 4'b1011);

        load_flags(4'b0000);
        setc = 1'b1; clrc = 1'b1;
        step();
        check("setc_clrc_hold", flag_mask, 4'b0000);
        check("proto_err_set", {3'b0, proto_err}, 4'd1);
        step();
        step();
        check("proto_err_sticky", {3'b0, proto_err}, 4'd1);

        setc = 1'b1;
        step();
        check("setc", flag_mask, 4'b0100);
        clrc = 1'b1;
        step();
        check("clrc", flag_mask, 4'b0000);

        load_flags(4'b1010);
        int_save = 1'b1;
        step();
        check("save1_empty", {3'b0, shadow_empty}, 4'd0);
        check("save1_full", {3'b0, shadow_full}, 4'd0);
        load_flags(4'b0110);
        int_save = 1'b1;
        step();
        check("save2_full", {3'b0, shadow_full}, 4'd1);
        load_flags(4'b0000);

        int_save = 1'b1;
        step();
        check("overflow_stk_err", {3'b0, stk_err}, 4'd1);
        check("overflow_full", {3'b0, shadow_full}, 4'd1);

        int_restore = 1'b1;
        step();
        check("restore1", flag_mask, 4'b0110);
        check("restore1_full", {3'b0, shadow_full}, 4'd0);
        int_restore = 1'b1;
        step();
        check("restore2", flag_mask, 4'b1010);
        check("restore2_empty", {3'b0, shadow_empty}, 4'd1);

        rst = 1'b1;
        step();
        check("rst2_stk_err", {3'b0, stk_err}, 4'd0);
        check("rst2_proto_err", {3'b0, proto_err}, 4'd0);

        int_restore = 1'b1; alu_flag_we = 4'b0010; alu_flags = 4'b0010;
        step();
        check("underflow_alu", flag_mask, 4'b0010);
        check("underflow_stk_err", {3'b0, stk_err}, 4'd1);
        check("underflow_empty", {3'b0, shadow_empty}, 4'd1);

        rst = 1'b1;
        step();
        load_flags(4'b1100);
        int_save = 1'b1;
        step();
        load_flags(4'b0011);
        int_save = 1'b1; int_restore = 1'b1;
        step();
        check("save_restore_flags", flag_mask, 4'b1100);
        check("save_restore_empty", {3'b0, shadow_empty}, 4'd1);
        check("save_restore_proto", {3'b0, proto_err}, 4'd1);
        check("save_restore_stk", {3'b0, stk_err}, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ccr_flag_unit.md
Name: ccr_flag_unit

Overview:
Condition-code register (CCR) stage that holds the Z/N/C/V flags and drives flag_mask into the branch-decision logic directly downstream.
- Merges per-flag ALU writes, SETC/CLRC, and clear-on-consume for taken conditional branches.
- Saves flags on interrupt entry and restores them on RTI through an internal LIFO shadow stack.
- Flags protocol violations through sticky error outputs.

Parameters:
NEST_DEPTH, 2, number of interrupt nesting levels held in the shadow stack (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
alu_flags  input  4  new flag values from ALU, bit0=Z, bit1=N, bit2=C, bit3=V
alu_flag_we  input  4  per-flag write enable, same bit order
setc  input  1  SETC instruction: force C=1
clrc  input  1  CLRC instruction: force C=0
b_take  input  1  branch taken this cycle, from branch decision logic
btype  input  3  branch type of the resolving instruction (BR_* codes)
int_save  input  1  interrupt entry: push current flags
int_restore  input  1  RTI: pop flags
flag_mask  output  4  current flags to branch logic, bit0=Z, bit1=N, bit2=C, bit3=V
shadow_empty  output  1  shadow stack holds no entries
shadow_full  output  1  shadow stack holds NEST_DEPTH entries
stk_err  output  1  sticky: push while full or pop while empty
proto_err  output  1  sticky: illegal simultaneous controls

Behaviour:
- Reset: flags=4'b0000, stack pointer=0, shadow_empty=1, shadow_full=0, stk_err=0, proto_err=0. Stack contents are don't-care.
- Registers update on the rising clk edge. Without FLAG_FWD_EN, flag_mask equals the flag register, so updates appear one cycle later.
- Next-state per flag, priority high to low:
  1. Valid int_restore: all four flags := popped entry. Every other source is ignored that cycle.
  2. C only: setc and clrc both high -> C holds and proto_err is set. Otherwise setc -> C=1, clrc -> C=0.
  3. alu_flag_we[i]=1 -> flag[i] := alu_flags[i]. ALU write beats consume-clear because it is the newer value.
  4. Consume-clear when b_take=1:
     - BR_JZ (001) clears Z; BR_JN (010) clears N; BR_JC (011) clears C; BR_JV (100) clears V.
     - BR_NONE, BR_LOOP, BR_JMP and BR_RET clear nothing.
  5. Otherwise the flag holds.
- int_save:
  - Pushes the current registered flags (pre-update value) and increments the pointer.
  - When full: push is dropped, stk_err is set, flag updates still proceed.
- int_restore:
  - When not empty: pops the top entry and decrements the pointer.
  - When empty: pop is ignored, stk_err is set, other updates proceed normally.
- int_save and int_restore together:
  - Restore executes and save is dropped; proto_err is set.
  - If the stack is empty, stk_err is also set and the flags follow normal priority.
- shadow_full and shadow_empty are registered and derived from the pointer after the update.
- Sticky errors clear only on rst.
- rst during any operation: reset values apply next edge and the stack is logically emptied.

Optional Feature:
FLAG_FWD_EN
- Defined: flag_mask is combinational and equals the computed next-state flags, so same-cycle ALU, SETC/CLRC and restore results are forwarded. Consume-clear is excluded from forwarding to avoid a combinational loop through b_take.
- Undefined: flag_mask is the registered flags only.

Decomposition:
- Shared package (ccr_pkg):
  - BR_NONE..BR_RET 3-bit codes: 000, 001, 010, 011, 100, 101, 110, 111.
  - Flag indices: FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3.
- Sub-module ccr_shadow_stack:
  - Parameterised LIFO of 4-bit entries with push/pop, full/empty and an err pulse.
  - Its pointer width is clog2(NEST_DEPTH+1).
- Top level holds the flag register, the priority merge and the sticky errors.

Test Plan:
- Reset, then alu_flag_we=4'b1111, alu_flags=4'b0101 -> flag_mask=4'b0101 next cycle (same cycle with FLAG_FWD_EN).
- Flags=4'b0001, b_take=1, btype=001 -> Z cleared, flag_mask=4'b0000. Same stimulus with btype=101 -> flags unchanged.
- Flags=4'b0001, b_take=1, btype=001, alu_flag_we=4'b0001, alu_flags=4'b0001 -> Z stays 1 (ALU wins).
- setc=1 and clrc=1 with C=0 -> C stays 0, proto_err=1 and stays 1 until rst.
- Flags=4'b1010 then int_save; flags=4'b0110 then int_save; set flags=0; int_restore twice -> 4'b0110 then 4'b1010. shadow_full=1 after the second save with NEST_DEPTH=2; shadow_empty=1 at the end.
- Third int_save while full -> stk_err=1, pointer unchanged. int_restore on empty stack with alu_flag_we=4'b0010, alu_flags=4'b0010 -> N=1, stk_err=1.
